// File: rtl/switch_autorepeat_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : switch_autorepeat_counter_if
// Purpose  : Groups the control and status signals of the switch
//            auto-repeat counter.
//            master : drives level_in / en / count_clr and observes the status
//                     outputs (the upstream / control side).
//            slave  : the counter itself.
// Signals  : level_in      debounced switch level
//            en            step enable
//            count_clr     synchronous clear of count
//            step_pulse    one-cycle pulse per step
//            repeat_active high while auto-repeating
//            count         wrap-around step counter
// Revision : 1.0  initial release
// ============================================================================
interface switch_autorepeat_counter_if #(
  parameter int CNT_W = 8
);
  logic             level_in;
  logic             en;
  logic             count_clr;
  logic             step_pulse;
  logic             repeat_active;
  logic [CNT_W-1:0] count;

  modport master (
    output level_in,
    output en,
    output count_clr,
    input  step_pulse,
    input  repeat_active,
    input  count
  );

  modport slave (
    input  level_in,
    input  en,
    input  count_clr,
    output step_pulse,
    output repeat_active,
    output count
  );
endinterface : switch_autorepeat_counter_if
`default_nettype wire

// File: rtl/switch_autorepeat_counter.sv
`default_nettype none
// ============================================================================
// Module   : switch_autorepeat_counter
// Purpose  : Turns a debounced switch level into step pulses: one on press,
//            then auto-repeat steps after a hold delay at a fixed rate while
//            the switch stays held. Counts steps modulo 2^CNT_W.
// Ports    : clk            system clock
//            reset          asynchronous, active-high reset
//            bus (slave)    level_in, en, count_clr in;
//                           step_pulse, repeat_active, count out
// Revision : 1.0  initial release
// ============================================================================
module switch_autorepeat_counter #(
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000,
  parameter int TIMER_W       = 25,
  parameter int CNT_W         = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  switch_autorepeat_counter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  localparam logic [TIMER_W-1:0] HOLD_LAST   = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] REPEAT_LAST = TIMER_W'(REPEAT_CYCLES - 1);

  state_t             state;
  state_t             state_next;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_next;
  logic               level_q;
  logic               rise;
  logic               step_req;
  logic               step_fire;
  logic               step_pulse_r;
  logic               repeat_active_r;
  logic [CNT_W-1:0]   count_r;

  // level_q resets high so a switch already held at reset release is not
  // mistaken for a fresh press.
  assign rise      = bus.level_in & ~level_q;
  assign step_fire = step_req & bus.en;

  // Next-state / timer logic. A release always wins over a terminal count.
  always_comb begin
    state_next = state;
    timer_next = timer;
    step_req   = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_next = HOLD;
          timer_next = '0;
          step_req   = 1'b1;
        end
      end
      HOLD: begin
        if (!bus.level_in) begin
          state_next = IDLE;
          timer_next = '0;
        end else if (timer == HOLD_LAST) begin
          state_next = REPEAT;
          timer_next = '0;
          step_req   = 1'b1;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      REPEAT: begin
        if (!bus.level_in) begin
          state_next = IDLE;
          timer_next = '0;
        end else if (timer == REPEAT_LAST) begin
          timer_next = '0;
          step_req   = 1'b1;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      level_q <= 1'b1;
    end else begin
      state   <= state_next;
      timer   <= timer_next;
      level_q <= bus.level_in;
    end
  end

  // Outputs are registered; repeat_active follows the registered state so it
  // is high for exactly the cycles spent in REPEAT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_pulse_r    <= 1'b0;
      repeat_active_r <= 1'b0;
      count_r         <= '0;
    end else begin
      step_pulse_r    <= step_fire;
      repeat_active_r <= (state_next == REPEAT);
      if (bus.count_clr) begin
        count_r <= '0;
      end else if (step_fire) begin
        count_r <= count_r + 1'b1;
      end
    end
  end

  assign bus.step_pulse    = step_pulse_r;
  assign bus.repeat_active = repeat_active_r;
  assign bus.count         = count_r;

endmodule : switch_autorepeat_counter
`default_nettype wire

// File: tb/tb_switch_autorepeat_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_autorepeat_counter
// Purpose  : Self-checking bench for switch_autorepeat_counter with
//            HOLD_CYCLES=10, REPEAT_CYCLES=4, CNT_W=4. Directed scenarios
//            followed by randomized press/release/enable/clear traffic, all
//            compared each cycle with a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_switch_autorepeat_counter;

  localparam int HOLD   = 10;
  localparam int REP    = 4;
  localparam int CNT_W  = 4;

  logic clk;
  logic reset;

  switch_autorepeat_counter_if #(.CNT_W(CNT_W)) bus ();

  switch_autorepeat_counter #(
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP),
    .TIMER_W      (4),
    .CNT_W        (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: held = number of consecutive sampled-high edges since a valid
  // press (0 when not armed). Steps fall at held==1 and at
  // held == 1+HOLD+k*REP.
  int   held;
  logic prev_lv;
  int   m_count;
  logic m_pulse;
  logic m_ra;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    held    = 0;
    prev_lv = 1'b1;
    m_count = 0;
    m_pulse = 1'b0;
    m_ra    = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".step_pulse"}, int'(bus.step_pulse), int'(m_pulse));
    check({tag, ".repeat_active"}, int'(bus.repeat_active), int'(m_ra));
    check({tag, ".count"}, int'(bus.count), m_count);
  endtask

  // One clock cycle: drive inputs, let the edge happen, update model, check.
  task automatic step(input logic lv, input logic e, input logic clr, input string tag);
    logic stp;
    bus.level_in  = lv;
    bus.en        = e;
    bus.count_clr = clr;
    @(posedge clk);
    if (lv) begin
      if (held > 0) held++;
      else if (!prev_lv) held = 1;
    end else begin
      held = 0;
    end
    prev_lv = lv;
    stp = (held == 1) || (held >= HOLD + 1 && ((held - 1 - HOLD) % REP) == 0);
    m_pulse = stp & e;
    m_ra    = lv && (held >= HOLD + 1);
    if (clr) m_count = 0;
    else if (stp && e) m_count = (m_count + 1) % (1 << CNT_W);
    #1;
    check_all(tag);
  endtask

  task automatic run(input int n, input logic lv, input logic e, input string tag);
    for (int i = 0; i < n; i++) step(lv, e, 1'b0, tag);
  endtask

  initial begin
    bus.level_in  = 1'b1;
    bus.en        = 1'b1;
    bus.count_clr = 1'b0;
    reset         = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    #2 reset = 1'b0;

    // Held through reset release: no step until released and re-pressed.
    run(20, 1'b1, 1'b1, "held_at_reset");
    run(2, 1'b0, 1'b1, "release1");
    run(3, 1'b1, 1'b1, "repress");
    check("repress.count", int'(bus.count), 1);
    run(3, 1'b0, 1'b1, "release2");

    // Short press: one step, no repeat.
    run(5, 1'b1, 1'b1, "short");
    run(3, 1'b0, 1'b1, "short_rel");

    // 30-cycle hold: steps at 1,11,15,19,23,27.
    step(1'b0, 1'b1, 1'b1, "clr0");
    run(30, 1'b1, 1'b1, "hold30");
    check("hold30.count", int'(bus.count), 6);
    run(3, 1'b0, 1'b1, "hold30_rel");

    // Long hold with counter wrap (17 steps from 0 ends at 1).
    step(1'b0, 1'b1, 1'b1, "clr1");
    run(72, 1'b1, 1'b1, "wrap");
    check("wrap.count", int'(bus.count), 1);
    run(2, 1'b0, 1'b1, "wrap_rel");

    // count_clr coincident with the press step.
    step(1'b1, 1'b1, 1'b1, "clr_on_step");
    check("clr_on_step.pulse", int'(bus.step_pulse), 1);
    run(2, 1'b0, 1'b1, "clr_rel");

    // en low during hold, then resume on the original schedule.
    run(3, 1'b1, 1'b1, "en_a");
    run(15, 1'b1, 1'b0, "en_off");
    run(10, 1'b1, 1'b1, "en_on");
    run(2, 1'b0, 1'b1, "en_rel");

    // Asynchronous reset in the middle of REPEAT.
    run(14, 1'b1, 1'b1, "pre_reset");
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_all("async_reset");
    #2 reset = 1'b0;
    run(8, 1'b1, 1'b1, "post_reset_held");
    run(1, 1'b0, 1'b1, "post_reset_rel");
    run(3, 1'b1, 1'b1, "post_reset_press");

    // Randomized traffic.
    for (int r = 0; r < 40; r++) begin
      logic lv;
      int   len;
      lv  = r[0] ? 1'b0 : 1'b1;
      len = lv ? int'($urandom_range(1, 30)) : int'($urandom_range(1, 4));
      for (int i = 0; i < len; i++) begin
        step(lv, ($urandom_range(0, 9) != 0), ($urandom_range(0, 24) == 0), "rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_switch_autorepeat_counter
`default_nettype wire
